// File: rtl/ysyx_22040750_mdu_if.sv
// rtl/ysyx_22040750_mdu_if.sv - request/result bundle between the issue stage and the multiply/divide unit
interface ysyx_22040750_mdu_if #(
   parameter int XLEN = 64
) ();
   logic [XLEN-1:0] I_op1;
   logic [XLEN-1:0] I_op2;
   logic [2:0]      I_op;
   logic            I_word;
   logic            I_valid;
   logic            O_ready;
   logic            I_EX_MEM_ready;
   logic            I_flush;
   logic [XLEN-1:0] O_result;
   logic            O_result_valid;

   modport master (
      output I_op1, I_op2, I_op, I_word, I_valid, I_EX_MEM_ready, I_flush,
      input  O_ready, O_result, O_result_valid
   );

   modport slave (
      input  I_op1, I_op2, I_op, I_word, I_valid, I_EX_MEM_ready, I_flush,
      output O_ready, O_result, O_result_valid
   );
endinterface

// File: rtl/ysyx_22040750_mdu.sv
// rtl/ysyx_22040750_mdu.sv - iterative RV64M multiply/divide unit (shift-add multiply, restoring divide)
module ysyx_22040750_mdu #(
   parameter int XLEN     = 64,
   parameter int WORD_OPS = 1
) (
   input logic                I_sys_clk,
   input logic                I_rst,
   ysyx_22040750_mdu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);
   localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W   = HI_MASK | XLEN'(32'h8000_0000);

   function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
      ext32 = (x & ~HI_MASK) | ((sgn && x[31]) ? HI_MASK : '0);
   endfunction

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              fin;
   logic [2:0]        op_r;
   logic              word_r;
   logic              negq_r;
   logic              negr_r;
   logic [2*XLEN-1:0] a_reg;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_reg;
   logic              ready_r;
   logic              valid_r;
   logic [XLEN-1:0]   result_r;

   logic            word_in, is_div, s1, s2, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0] ext1, ext2, mag1, mag2;

   // Operands are reduced to magnitudes at acceptance; the sign is reapplied at completion.
   always_comb begin
      word_in  = (WORD_OPS != 0) && bus.I_word;
      is_div   = bus.I_op[2];
      s1       = (bus.I_op == 3'b100) || (bus.I_op == 3'b110) ||
                 (!word_in && ((bus.I_op == 3'b001) || (bus.I_op == 3'b010)));
      s2       = (bus.I_op == 3'b100) || (bus.I_op == 3'b110) ||
                 (!word_in && (bus.I_op == 3'b001));
      ext1     = word_in ? ext32(bus.I_op1, s1) : bus.I_op1;
      ext2     = word_in ? ext32(bus.I_op2, s2) : bus.I_op2;
      neg1     = s1 && ext1[XLEN-1];
      neg2     = s2 && ext2[XLEN-1];
      mag1     = neg1 ? -ext1 : ext1;
      mag2     = neg2 ? -ext2 : ext2;
      div_zero = is_div && (ext2 == '0);
      div_ovf  = is_div && s1 && (ext2 == '1) && (ext1 == (word_in ? MIN_W : MIN_X));
   end

   logic [XLEN:0]     trial, nxt_rem;
   logic              ge;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, raw, fin_res;

   always_comb begin
      trial   = {acc[XLEN-1:0], b_reg[XLEN-1]};
      ge      = trial >= {1'b0, a_reg[XLEN-1:0]};
      nxt_rem = ge ? (trial - {1'b0, a_reg[XLEN-1:0]}) : trial;
      prod    = negq_r ? -acc : acc;
      quo     = negq_r ? -b_reg : b_reg;
      rem     = negr_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      if (op_r[2])
         raw = op_r[1] ? rem : quo;
      else
         raw = ((op_r == 3'b000) || word_r) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      fin_res = word_r ? ext32(raw, 1'b1) : raw;
   end

   always_ff @(posedge I_sys_clk or negedge I_rst) begin
      if (!I_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         fin      <= 1'b0;
         op_r     <= '0;
         word_r   <= 1'b0;
         negq_r   <= 1'b0;
         negr_r   <= 1'b0;
         a_reg    <= '0;
         acc      <= '0;
         b_reg    <= '0;
         ready_r  <= 1'b1;
         valid_r  <= 1'b0;
         result_r <= '0;
      end else if (bus.I_flush) begin
         state    <= IDLE;
         fin      <= 1'b0;
         ready_r  <= 1'b1;
         valid_r  <= 1'b0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.I_valid) begin
               op_r    <= bus.I_op;
               word_r  <= word_in;
               cnt     <= word_in ? CW'(31) : CW'(XLEN-1);
               ready_r <= 1'b0;
               state   <= CALC;
               // Special divides preload the final quotient/remainder and finish on the next edge.
               fin     <= div_zero || div_ovf;
               if (div_zero) begin
                  a_reg  <= '0;
                  b_reg  <= '1;
                  acc    <= {{XLEN{1'b0}}, ext1};
                  negq_r <= 1'b0;
                  negr_r <= 1'b0;
               end else if (div_ovf) begin
                  a_reg  <= '0;
                  b_reg  <= ext1;
                  acc    <= '0;
                  negq_r <= 1'b0;
                  negr_r <= 1'b0;
               end else if (is_div) begin
                  a_reg  <= {{XLEN{1'b0}}, mag2};
                  b_reg  <= word_in ? (mag1 << (XLEN-32)) : mag1;
                  acc    <= '0;
                  negq_r <= neg1 ^ neg2;
                  negr_r <= neg1;
               end else begin
                  a_reg  <= {{XLEN{1'b0}}, mag1};
                  b_reg  <= mag2;
                  acc    <= '0;
                  negq_r <= neg1 ^ neg2;
                  negr_r <= 1'b0;
               end
            end
            CALC: if (fin) begin
               result_r <= fin_res;
               valid_r  <= 1'b1;
               fin      <= 1'b0;
               state    <= DONE;
            end else begin
               if (op_r[2]) begin
                  acc   <= {{(XLEN-1){1'b0}}, nxt_rem};
                  b_reg <= {b_reg[XLEN-2:0], ge};
               end else begin
                  if (b_reg[0]) acc <= acc + a_reg;
                  a_reg <= a_reg << 1;
                  b_reg <= b_reg >> 1;
               end
               if (cnt == '0) fin <= 1'b1;
               else           cnt <= cnt - CW'(1);
            end
            DONE: if (bus.I_EX_MEM_ready) begin
               state    <= IDLE;
               ready_r  <= 1'b1;
               valid_r  <= 1'b0;
               result_r <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.O_ready        = ready_r;
   assign bus.O_result_valid = valid_r;
   assign bus.O_result       = result_r;
endmodule

// File: tb/tb_ysyx_22040750_mdu.sv
// tb/tb_ysyx_22040750_mdu.sv - scoreboard bench for the multiply/divide unit
module tb_ysyx_22040750_mdu;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ysyx_22040750_mdu_if #(.XLEN(64)) bus ();
   ysyx_22040750_mdu #(.XLEN(64), .WORD_OPS(1)) dut (
      .I_sys_clk(clk),
      .I_rst    (rst_n),
      .bus      (bus)
   );

   typedef struct {
      logic [63:0] res;
      int          acc_cyc;
      int          lat;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        prev_v = 1'b0;
   logic [63:0] held = '0;

   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

   function automatic logic [63:0] ref_model(input logic [2:0] op, input bit w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [127:0] xa, xb, p;
      logic [63:0]  x, y, q, r, res;
      bit           sa, sbb;
      if (!op[2]) begin
         if (w) begin
            p = 128'(a[31:0]) * 128'(b[31:0]);
            return sext32(p[31:0]);
         end
         sa  = (op == 3'd1) || (op == 3'd2);
         sbb = (op == 3'd1);
         xa  = sa  ? {{64{a[63]}}, a} : {64'd0, a};
         xb  = sbb ? {{64{b[63]}}, b} : {64'd0, b};
         p   = xa * xb;
         return (op == 3'd0) ? p[63:0] : p[127:64];
      end
      sa = !op[0];
      x  = w ? (sa ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
      y  = w ? (sa ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
      if (y == 64'd0) begin
         q = '1; r = x;
      end else if (sa && x == 64'h8000_0000_0000_0000 && y == '1) begin
         q = x; r = 64'd0;
      end else if (sa) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
      res = op[1] ? r : q;
      return w ? sext32(res[31:0]) : res;
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input bit w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x, y;
      bit sa;
      sa = !op[0];
      x  = w ? (sa ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
      y  = w ? (sa ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
      if (op[2] && (y == 64'd0 || (sa && y == '1 &&
          x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))))
         return 1;
      return w ? 33 : 65;
   endfunction

   // Monitor: pops the scoreboard on the first cycle of each result.
   always @(negedge clk) begin
      exp_t e;
      if (bus.O_result_valid) begin
         if (!prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_result_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_result"}, bus.O_result, e.res);
               chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
            held = bus.O_result;
         end else begin
            chk("result_stable_in_done", bus.O_result, held);
         end
      end else begin
         chk("result_zero_when_invalid", bus.O_result, 64'd0);
      end
      prev_v = bus.O_result_valid;
   end

   task automatic wait_ready();
      int n = 0;
      while (!bus.O_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.O_ready) chk("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic issue(input logic [2:0] op, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input int hold, input string name);
      exp_t e;
      int   n;
      wait_ready();
      bus.I_op   = op;
      bus.I_word = w;
      bus.I_op1  = a;
      bus.I_op2  = b;
      bus.I_valid = 1'b1;
      @(posedge clk);
      #1;
      e.res     = ref_model(op, w, a, b);
      e.acc_cyc = cyc;
      e.lat     = exp_lat(op, w, a, b);
      e.name    = name;
      sb.push_back(e);
      bus.I_valid = 1'b0;
      bus.I_op1   = {$urandom, $urandom};
      bus.I_op2   = {$urandom, $urandom};
      bus.I_op    = 3'($urandom);
      bus.I_word  = 1'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.O_result_valid && n < 100);
      if (!bus.O_result_valid) begin
         chk({name, "_valid_timeout"}, 64'd0, 64'd1);
         return;
      end
      if (hold < 0) hold = $urandom_range(0, 3);
      repeat (hold) begin
         chk("ready_low_in_done", 64'(bus.O_ready), 64'd0);
         @(negedge clk);
      end
      bus.I_EX_MEM_ready = 1'b1;
      @(negedge clk);
      bus.I_EX_MEM_ready = 1'b0;
      chk("ready_after_handoff", 64'(bus.O_ready), 64'd1);
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 6))
         0:       return 64'h8000_0000_0000_0000;
         1:       return '1;
         2:       return 64'hFFFF_FFFF_8000_0000;
         3:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  op;
      logic [63:0] a, b;
      bit          w;
      rst_n = 1'b0;
      bus.I_op1 = '0; bus.I_op2 = '0; bus.I_op = '0; bus.I_word = 1'b0;
      bus.I_valid = 1'b0; bus.I_EX_MEM_ready = 1'b0; bus.I_flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(bus.O_ready), 64'd1);
      chk("reset_valid", 64'(bus.O_result_valid), 64'd0);
      chk("reset_result", bus.O_result, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(3'd0, 1'b0, '1, 64'd2, -1, "mul_allones_x2");
      issue(3'd3, 1'b0, '1, 64'd2, -1, "mulhu_allones_x2");
      issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, '1, -1, "mulh_min_x_neg1");
      issue(3'd2, 1'b0, '1, '1, -1, "mulhsu_neg1_x_max");
      issue(3'd4, 1'b0, -64'sd7, 64'd2, -1, "div_neg7_2");
      issue(3'd6, 1'b0, -64'sd7, 64'd2, -1, "rem_neg7_2");
      issue(3'd5, 1'b0, 64'd7, 64'd0, -1, "divu_by_zero");
      issue(3'd6, 1'b0, 64'd7, 64'd0, -1, "rem_by_zero");
      issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, -1, "div_overflow");
      issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, -1, "rem_overflow");
      issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, -1, "divw_min_1");
      issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, -1, "mulw_max_x2");
      issue(3'd3, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, -1, "mulhu_word_as_mulw");
      issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, -1, "divw_overflow");
      issue(3'd7, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h5_0000_0000, -1, "remuw_by_zero");
      issue(3'd2, 1'b0, 64'd12345, 64'd678, 5, "mulhsu_hold5");

      // flush mid-CALC: no result may appear
      wait_ready();
      bus.I_op = 3'd0; bus.I_word = 1'b0; bus.I_op1 = 64'd99; bus.I_op2 = 64'd77;
      bus.I_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.I_valid = 1'b0;
      repeat (10) @(negedge clk);
      bus.I_flush = 1'b1;
      bus.I_EX_MEM_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.I_flush = 1'b0;
      bus.I_EX_MEM_ready = 1'b0;
      chk("flush_ready", 64'(bus.O_ready), 64'd1);
      chk("flush_valid", 64'(bus.O_result_valid), 64'd0);
      repeat (80) @(negedge clk);

      // flush overrides acceptance in IDLE
      bus.I_valid = 1'b1;
      bus.I_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.I_valid = 1'b0;
      bus.I_flush = 1'b0;
      chk("flush_blocks_accept", 64'(bus.O_ready), 64'd1);
      repeat (3) @(negedge clk);

      // asynchronous reset mid-CALC
      wait_ready();
      bus.I_op = 3'd4; bus.I_word = 1'b0; bus.I_op1 = 64'd1000; bus.I_op2 = 64'd7;
      bus.I_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.I_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(bus.O_result_valid), 64'd0);
      chk("async_reset_ready", 64'(bus.O_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd0, 1'b0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0005, -1, "mul_after_reset");

      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         a  = rnd_operand();
         b  = rnd_operand();
         if ($urandom_range(0, 9) == 0) b = 64'd0;
         issue(op, w, a, b, -1, "random");
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
